// File: rtl/cordic_pkg.sv
// Shared constants for the pipelined CORDIC vectoring engine: arctangent table,
// quarter-turn constant and the 1/K shift-add list used when CORDIC_GAIN_COMP_EN is defined.
package cordic_pkg;

  localparam int MAX_STAGES = 16;

  // atan(2^-i) with 2^31 == pi; rescaled with rounding to the phase width in use.
  localparam logic [31:0] ATAN_LUT [MAX_STAGES] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D
  };

  // 1/K ~ x/2 + x/8 - x/64 - x/512
  localparam int   INV_GAIN_TERMS = 4;
  localparam int   INV_GAIN_SHIFT [INV_GAIN_TERMS] = '{1, 3, 6, 9};
  localparam logic INV_GAIN_NEG   [INV_GAIN_TERMS] = '{1'b0, 1'b0, 1'b1, 1'b1};

  function automatic logic [31:0] atan_q(input int idx, input int angle_w);
    int          sh;
    logic [31:0] v;
    sh = 32 - angle_w;
    v  = ATAN_LUT[idx];
    if (sh <= 0) return v;
    return (v + (32'd1 << (sh - 1))) >> sh;
  endfunction

  function automatic logic [31:0] half_pi(input int angle_w);
    return 32'd1 << (angle_w - 2);
  endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One registered CORDIC vectoring micro-rotation; drives y toward zero and
// accumulates the applied angle. Holds all state while en is low.
module cordic_vec_stage
  import cordic_pkg::*;
#(
  parameter int SHIFT   = 0,
  parameter int IW      = 16,
  parameter int ANGLE_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      in_valid,
  input  logic signed [IW-1:0]      in_x,
  input  logic signed [IW-1:0]      in_y,
  input  logic        [ANGLE_W-1:0] in_z,
  output logic                      out_valid,
  output logic signed [IW-1:0]      out_x,
  output logic signed [IW-1:0]      out_y,
  output logic        [ANGLE_W-1:0] out_z
);

  localparam logic [ANGLE_W-1:0] ATAN = ANGLE_W'(atan_q(SHIFT, ANGLE_W));

  logic signed [IW-1:0] x_sh;
  logic signed [IW-1:0] y_sh;

  assign x_sh = in_x >>> SHIFT;
  assign y_sh = in_y >>> SHIFT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      // y == 0 counts as non-negative, so (0,0) still takes a defined path
      if (!in_y[IW-1]) begin
        out_x <= in_x + y_sh;
        out_y <= in_y - x_sh;
        out_z <= in_z + ATAN;
      end else begin
        out_x <= in_x - y_sh;
        out_y <= in_y + x_sh;
        out_z <= in_z - ATAN;
      end
    end
  end

endmodule

// File: rtl/cordic_vectoring_pipe.sv
// Fully pipelined CORDIC vectoring engine: (x,y) -> magnitude, atan2 phase, with
// valid/ready flow control. Define CORDIC_GAIN_COMP_EN to add a 1/K output stage.
module cordic_vectoring_pipe
  import cordic_pkg::*;
#(
  parameter int WIDTH   = 14,
  parameter int STAGES  = 12,
  parameter int ANGLE_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH-1:0]   in_x,
  input  logic signed [WIDTH-1:0]   in_y,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [WIDTH+1:0]   out_mag,
  output logic        [ANGLE_W-1:0] out_phase
);

  localparam int IW = WIDTH + 2;
  localparam logic [ANGLE_W-1:0] HALF_PI = ANGLE_W'(half_pi(ANGLE_W));

  // Handshake: a sample moves on in_valid & in_ready, a result on out_valid & out_ready.
  // The whole pipeline steps together whenever the output slot is empty or being taken,
  // so a stalled result freezes every stage behind it (bubbles are not squeezed out).
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Element 0 is the pre-rotation register, element i+1 the output of stage i.
  logic                     sv [STAGES+1];
  logic signed [IW-1:0]     sx [STAGES+1];
  logic signed [IW-1:0]     sy [STAGES+1];
  logic        [ANGLE_W-1:0] sz [STAGES+1];

  logic signed [IW-1:0]      ext_x, ext_y;
  logic signed [IW-1:0]      pre_x, pre_y;
  logic        [ANGLE_W-1:0] pre_z;

  assign ext_x = {{2{in_x[WIDTH-1]}}, in_x};
  assign ext_y = {{2{in_y[WIDTH-1]}}, in_y};

  // Fold the left half-plane into the right so the stages only need +/- pi/2 range.
  always_comb begin
    pre_x = ext_x;
    pre_y = ext_y;
    pre_z = '0;
    if (ext_x[IW-1]) begin
      if (!ext_y[IW-1]) begin
        pre_x = ext_y;
        pre_y = -ext_x;
        pre_z = HALF_PI;
      end else begin
        pre_x = -ext_y;
        pre_y = ext_x;
        pre_z = -HALF_PI;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sv[0] <= 1'b0;
      sx[0] <= '0;
      sy[0] <= '0;
      sz[0] <= '0;
    end else if (adv) begin
      sv[0] <= in_valid;
      sx[0] <= pre_x;
      sy[0] <= pre_y;
      sz[0] <= pre_z;
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    cordic_vec_stage #(
      .SHIFT  (i),
      .IW     (IW),
      .ANGLE_W(ANGLE_W)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (adv),
      .in_valid (sv[i]),
      .in_x     (sx[i]),
      .in_y     (sy[i]),
      .in_z     (sz[i]),
      .out_valid(sv[i+1]),
      .out_x    (sx[i+1]),
      .out_y    (sy[i+1]),
      .out_z    (sz[i+1])
    );
  end

`ifdef CORDIC_GAIN_COMP_EN
  logic signed [IW-1:0] mag_comp;

  always_comb begin
    mag_comp = '0;
    for (int k = 0; k < INV_GAIN_TERMS; k++) begin
      if (INV_GAIN_NEG[k]) mag_comp = mag_comp - (sx[STAGES] >>> INV_GAIN_SHIFT[k]);
      else                 mag_comp = mag_comp + (sx[STAGES] >>> INV_GAIN_SHIFT[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_phase <= '0;
    end else if (adv) begin
      out_valid <= sv[STAGES];
      out_mag   <= mag_comp;
      out_phase <= sz[STAGES];
    end
  end
`else
  assign out_valid = sv[STAGES];
  assign out_mag   = sx[STAGES];
  assign out_phase = sz[STAGES];
`endif

endmodule
